// File: rtl/ff_conv_sched.sv
// Round-robin scheduler that lets NREQ requesters share one JK flip-flop core.
// Build option FFC_TOGGLE_EN: when defined, op 11 toggles the core; otherwise it is rejected with err.
module ff_conv_sched #(
  parameter int unsigned NREQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] op,
  output logic [NREQ-1:0]   gnt,
  output logic              j,
  output logic              k,
  input  logic              q_in,
  output logic              q_out,
  output logic              done,
  output logic              err,
  output logic              busy
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NREQ - 1);

`ifdef FFC_TOGGLE_EN
  localparam bit ToggleEn = 1'b1;
`else
  localparam bit ToggleEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StDrive, StSample} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] win_q, win_d;
  logic [1:0]      op_q, op_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            j_q, j_d, k_q, k_d;
  logic            q_out_q, q_out_d;
  logic            done_q, done_d, err_q, err_d, busy_q, busy_d;

  logic [1:0]      op_a [NREQ];
  logic [IdxW-1:0] pick;
  logic            found;
  int unsigned     idx;

  for (genvar g = 0; g < NREQ; g++) begin : gen_op_unpack
    assign op_a[g] = op[2*g+1 -: 2];
  end

  // Search starts one past the last winner so priority rotates.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = (32'(ptr_q) + i) % NREQ;
      if (!found && req[IdxW'(idx)]) begin
        found = 1'b1;
        pick  = IdxW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    op_d    = op_q;
    gnt_d   = '0;
    j_d     = 1'b0;
    k_d     = 1'b0;
    q_out_d = q_out_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    busy_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StDrive;
          win_d   = pick;
          op_d    = op_a[pick];
          gnt_d   = NREQ'(1) << pick;
          // Without toggle support op 11 is granted but leaves the core untouched.
          if (!(op_a[pick] == 2'b11 && !ToggleEn)) begin
            j_d = op_a[pick][1];
            k_d = op_a[pick][0];
          end
          busy_d  = 1'b1;
        end
      end
      StDrive: begin
        state_d = StSample;
        busy_d  = 1'b1;
      end
      StSample: begin
        state_d = StIdle;
        q_out_d = q_in;
        done_d  = 1'b1;
        err_d   = (op_q == 2'b11) && !ToggleEn;
        ptr_d   = win_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= LastIdx;
      win_q   <= '0;
      op_q    <= 2'b00;
      gnt_q   <= '0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      q_out_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      op_q    <= op_d;
      gnt_q   <= gnt_d;
      j_q     <= j_d;
      k_q     <= k_d;
      q_out_q <= q_out_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt   = gnt_q;
  assign j     = j_q;
  assign k     = k_q;
  assign q_out = q_out_q;
  assign done  = done_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_ff_conv_sched.sv
// Bench for ff_conv_sched: behavioural JK core plus a transaction-level reference model.
module tb_ff_conv_sched;

  localparam int unsigned NREQ = 4;
`ifdef FFC_TOGGLE_EN
  localparam bit TOG = 1'b1;
`else
  localparam bit TOG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [7:0] op  = '0;
  logic [3:0] gnt;
  logic       j, k, q_in, q_out, done, err, busy;

  logic core_q   = 1'b0;
  logic load     = 1'b0;
  logic load_val = 1'b0;

  int checks = 0;
  int errors = 0;
  int last   = 3;

  ff_conv_sched #(.NREQ(NREQ)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .op    (op),
    .gnt   (gnt),
    .j     (j),
    .k     (k),
    .q_in  (q_in),
    .q_out (q_out),
    .done  (done),
    .err   (err),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Shared JK core; the bench can preload it to set up a known starting Q.
  always @(posedge clk) begin
    if (load) core_q <= load_val;
    else begin
      case ({j, k})
        2'b01:   core_q <= 1'b0;
        2'b10:   core_q <= 1'b1;
        2'b11:   core_q <= ~core_q;
        default: core_q <= core_q;
      endcase
    end
  end
  assign q_in = core_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_rr(input logic [3:0] rq);
    int idx;
    for (int i = 1; i <= 4; i++) begin
      idx = (last + i) % 4;
      if (rq[idx]) return idx;
    end
    return 0;
  endfunction

  function automatic logic exp_q(input logic [1:0] o, input logic qv);
    case (o)
      2'b00:   return qv;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return TOG ? ~qv : qv;
    endcase
  endfunction

  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk({tag, "_gnt"}, 32'(gnt), 32'(0));
    chk({tag, "_jk"}, 32'({j, k}), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(0));
  endtask

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic txn(input logic [3:0] rq, input logic [7:0] ops, input logic qv,
                     input logic [3:0] drive_req, input logic [3:0] sample_req);
    int         w;
    logic [1:0] o;
    logic [3:0] oh;
    logic [1:0] ejk;
    req = rq; op = ops; load = 1'b1; load_val = qv;
    w   = pick_rr(rq);
    o   = 2'(ops >> (2 * w));
    oh  = 4'(1 << w);
    ejk = (o == 2'b11 && !TOG) ? 2'b00 : o;
    @(negedge clk);
    load = 1'b0;
    chk("drive_gnt", 32'(gnt), 32'(oh));
    chk("drive_jk", 32'({j, k}), 32'(ejk));
    chk("drive_busy", 32'(busy), 32'(1));
    chk("drive_done", 32'(done), 32'(0));
    req = drive_req; op = 8'($urandom);
    @(negedge clk);
    chk("sample_gnt", 32'(gnt), 32'(0));
    chk("sample_jk", 32'({j, k}), 32'(0));
    chk("sample_busy", 32'(busy), 32'(1));
    chk("sample_done", 32'(done), 32'(0));
    req = sample_req; op = 8'($urandom);
    @(negedge clk);
    chk("done", 32'(done), 32'(1));
    chk("q_out", 32'(q_out), 32'(exp_q(o, qv)));
    chk("err", 32'(err), 32'(o == 2'b11 && !TOG));
    chk("done_busy", 32'(busy), 32'(0));
    chk("done_gnt", 32'(gnt), 32'(0));
    last = w;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_jk", 32'({j, k}), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_qout", 32'(q_out), 32'(0));
    rst = 1'b0;
    idle_chk("idle0");

    // All requesters held with hold ops: grants rotate 0,1,2,3 every 3 cycles.
    for (int n = 0; n < 4; n++) txn(4'b1111, 8'h00, 1'b0, 4'b1111, 4'b1111);
    req = '0;
    idle_chk("idle1");

    // Set requester 0 with core at 0.
    txn(4'b0001, 8'b0000_0010, 1'b0, 4'b0000, 4'b0000);
    // Toggle on requester 2 with core at 1.
    txn(4'b0100, 8'b0011_0000, 1'b1, 4'b0000, 4'b0000);

    // Requester 1 pulses only while requester 0 is in DRIVE: never granted.
    txn(4'b0001, 8'b0000_0001, 1'b1, 4'b0010, 4'b0000);
    req = '0;
    for (int n = 0; n < 3; n++) idle_chk("nopulse");

    // Reset during SAMPLE of a grant to requester 1 abandons it and resets priority.
    txn(4'b0001, 8'h00, 1'b1, 4'b0000, 4'b0000);
    req = 4'b0010; op = 8'b0000_0100;
    @(negedge clk);
    chk("r1_gnt", 32'(gnt), 32'(4'b0010));
    chk("r1_jk", 32'({j, k}), 32'(2'b01));
    req = '0;
    @(negedge clk);
    rst = 1'b1; req = 4'b0011;
    @(negedge clk);
    chk("rst_mid_done", 32'(done), 32'(0));
    chk("rst_mid_err", 32'(err), 32'(0));
    chk("rst_mid_busy", 32'(busy), 32'(0));
    chk("rst_mid_gnt", 32'(gnt), 32'(0));
    chk("rst_mid_qout", 32'(q_out), 32'(0));
    rst  = 1'b0;
    last = 3;
    txn(4'b0011, 8'b0000_0110, 1'b0, 4'b0000, 4'b0000);

    // Random traffic, including req/op changes during DRIVE and SAMPLE.
    for (int n = 0; n < 40; n++) begin
      txn(4'($urandom_range(1, 15)), 8'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        req = '0;
        idle_chk("gap");
      end
    end

    req = '0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ff_conv_sched.md
FF_CONV_SCHED -- requirements
Module: ff_conv_sched

Interface
REQ-001 Parameter: NREQ, default 4, number of requesters sharing one JK-converted flip-flop core; legal range 2..8.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: req  input  NREQ  per-requester request; held high until matching gnt bit seen.
REQ-005 Port: op  input  2*NREQ  per-requester command, op[2i+1:2i]: 00 hold, 01 reset, 10 set, 11 toggle.
REQ-006 Port: gnt  output  NREQ  one-hot grant pulse, one cycle.
REQ-007 Port: j  output  1  J drive to shared flip-flop core.
REQ-008 Port: k  output  1  K drive to shared flip-flop core.
REQ-009 Port: q_in  input  1  Q from shared flip-flop core.
REQ-010 Port: q_out  output  1  core Q captured after the granted operation.
REQ-011 Port: done  output  1  one-cycle pulse; q_out valid for granted requester.
REQ-012 Port: err  output  1  one-cycle pulse coincident with done when the operation was rejected.
REQ-013 Port: busy  output  1  high whenever FSM is not IDLE.

Function
REQ-014 FSM states IDLE, DRIVE, SAMPLE; all outputs registered.
REQ-015 IDLE, req nonzero at edge E0: round-robin pick, search starting at index after last granted requester, wrapping NREQ-1 -> 0; latch winner index and its op; go DRIVE.
REQ-016 Cycle after E0 (DRIVE): gnt[winner]=1, j/k from latched op: 00->j=0,k=0; 01->0,1; 10->1,0; 11->1,1.
REQ-017 Edge E1: core updates; go SAMPLE; gnt=0, j=0, k=0.
REQ-018 Edge E2: q_out<=q_in, done=1 for one cycle; go IDLE; round-robin pointer <= winner.
REQ-019 Fixed latency: req sampled E0 -> done high in cycle after E2; max throughput one operation per 3 cycles; next arbitration at E3.
REQ-020 req deasserted before sampling: no grant, no core activity; req/op changes during DRIVE/SAMPLE ignored.
REQ-021 Single requester asserting continuously: granted every 3 cycles; all requesters asserted: grants rotate 0,1,...,NREQ-1,0.
REQ-022 j and k never high outside DRIVE; gnt never multi-hot.
REQ-023 q_out holds its value between done pulses.

Reset
REQ-024 rst high at an edge: state IDLE, gnt=0, j=0, k=0, done=0, err=0, busy=0, q_out=0, round-robin pointer set so requester 0 has highest priority next.
REQ-025 rst in DRIVE or SAMPLE: operation abandoned, no done/err pulse; core flip-flop is not reset by this block and keeps whatever the last edge produced.
REQ-026 rst dominates all other inputs in the same cycle.

Configuration
REQ-027 Macro FFC_TOGGLE_EN defined: op 11 drives j=1,k=1 (core toggles); err never asserts.
REQ-028 Macro FFC_TOGGLE_EN undefined: op 11 is granted but drives j=0,k=0 in DRIVE; done and err pulse together at E2; q_out = unchanged q_in.

Verification
REQ-029 rst 2 cycles, then idle -> j=k=0, gnt=0, done=0, busy=0, q_out=0.
REQ-030 req=0001, op0=10 (core q=0) -> gnt=0001 one cycle after sample with j=1,k=0; done two cycles later with q_out=1.
REQ-031 req=1111, ops all 00, held 12 cycles -> gnt sequence 0001,0010,0100,1000, spaced 3 cycles, q_out unchanged.
REQ-032 req=0100, op2=11, core q=1 -> with FFC_TOGGLE_EN: q_out=0, err=0; without: q_out=1, err=1 with done.
REQ-033 Grant to requester 1 (op 01), rst asserted in SAMPLE cycle -> no done, all outputs reset values next cycle, next grant goes to requester 0 if requesting.
REQ-034 req=0010 pulsed one cycle while FSM in DRIVE for requester 0 -> requester 1 never granted.
